// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle data memory between the fetch
// port (port 0) and the MEM-stage data port (port 1). Accesses are
// serialised, with port 1 served first. A single combinational stall holds
// the pipeline until every active port has completed its access for the
// current pipeline cycle.
// Optional build macro MEM_ARB_WATCHDOG_EN adds an access watchdog and the
// sticky err_o output.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              Clock_i,
    input  logic              Reset_n_i,
    input  logic              req0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack0_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
`ifdef MEM_ARB_WATCHDOG_EN
    output logic              err_o,
`endif
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state;
    logic              done0;
    logic              done1;
    logic              grant;
    logic              pend0;
    logic              pend1;
    logic              finish;
    logic              timeout_hit;
    logic [DATA_W-1:0] fill_data;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("mem_port_arbiter: TIMEOUT must be at least 1");
    end

    // Per-port outstanding work for the current pipeline cycle.
    always_comb begin
        pend0 = req0_i & ~done0;
        pend1 = req1_i & ~done1;
    end

    assign stall_o = pend0 | pend1;

`ifdef MEM_ARB_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt;

    assign timeout_hit = (state == WAIT) && !mem_ack_i && (wd_cnt == CNT_W'(TIMEOUT - 1));

    // Watchdog: count WAIT cycles and latch a sticky error on forced completion.
    always_ff @(posedge Clock_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            wd_cnt <= '0;
            err_o  <= 1'b0;
        end else begin
            if (state == WAIT && !finish) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end else begin
                wd_cnt <= '0;
            end
            if (timeout_hit) begin
                err_o <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Access completion and the data loaded into the read register.
    always_comb begin
        finish    = (state == WAIT) && (mem_ack_i || timeout_hit);
        fill_data = mem_ack_i ? mem_rdata_i : '1;
    end

    // Arbitration FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge Clock_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state       <= IDLE;
            done0       <= 1'b0;
            done1       <= 1'b0;
            grant       <= 1'b0;
            ack0_o      <= 1'b0;
            ack1_o      <= 1'b0;
            rdata0_o    <= '0;
            rdata1_o    <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            ack0_o <= 1'b0;
            ack1_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend1) begin
                        grant       <= 1'b1;
                        mem_we_o    <= we1_i;
                        mem_addr_o  <= addr1_i;
                        mem_wdata_o <= wdata1_i;
                        mem_req_o   <= 1'b1;
                        state       <= WAIT;
                    end else if (pend0) begin
                        grant       <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= addr0_i;
                        mem_wdata_o <= '0;
                        mem_req_o   <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (finish) begin
                        mem_req_o <= 1'b0;
                        state     <= IDLE;
                        if (grant) begin
                            done1  <= 1'b1;
                            ack1_o <= 1'b1;
                            if (!mem_we_o) begin
                                rdata1_o <= fill_data;
                            end
                        end else begin
                            done0    <= 1'b1;
                            ack0_o   <= 1'b1;
                            rdata0_o <= fill_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // Pipeline advance edge; placed last so it overrides a done set on
            // the same edge for a port whose request was already withdrawn.
            if (!stall_o) begin
                done0 <= 1'b0;
                done1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized requester/memory traffic compared every
// cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          Clock_i = 1'b0;
    logic          Reset_n_i;
    logic          req0_i;
    logic [AW-1:0] addr0_i;
    logic          req1_i;
    logic          we1_i;
    logic [AW-1:0] addr1_i;
    logic [DW-1:0] wdata1_i;
    logic          ack0_o;
    logic [DW-1:0] rdata0_o;
    logic          ack1_o;
    logic [DW-1:0] rdata1_o;
    logic          stall_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
`ifdef MEM_ARB_WATCHDOG_EN
    logic          err_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .Clock_i(Clock_i), .Reset_n_i(Reset_n_i),
        .req0_i(req0_i), .addr0_i(addr0_i),
        .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
        .ack0_o(ack0_o), .rdata0_o(rdata0_o), .ack1_o(ack1_o), .rdata1_o(rdata1_o),
        .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
`ifdef MEM_ARB_WATCHDOG_EN
        .err_o(err_o),
`endif
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 Clock_i = ~Clock_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int          lat_cfg = 0;      // <0 selects random latency
    bit          mem_mute = 0;
    bit          use_fixed = 1;
    bit          spurious_en = 0;
    logic [31:0] fixed_data = 32'h8C22_0004;
    int          force_req = 0;
    int          force_seen = 0;
    int          mem_lat = 0;
    bit          mem_busy = 0;

    function automatic int next_lat();
        return (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 3));
    endfunction

    always @(negedge Clock_i) begin
        if (!Reset_n_i) begin
            mem_ack_i = 1'b0;
            mem_busy  = 0;
        end else if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            mem_busy  = 0;
        end else if (force_req != force_seen) begin
            force_seen  = force_req;
            mem_ack_i   = 1'b1;
            mem_rdata_i = $urandom;
        end else if (mem_req_o) begin
            if (!mem_mute) begin
                if (!mem_busy) begin
                    mem_busy = 1;
                    mem_lat  = next_lat();
                end
                if (mem_lat == 0) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = use_fixed ? fixed_data : $urandom;
                end else begin
                    mem_lat--;
                end
            end
        end else begin
            mem_busy = 0;
            if (spurious_en && $urandom_range(0, 15) == 0) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = $urandom;
            end
        end
    end

    // ---------------- transaction-level model ----------------
    bit          m_busy = 0;
    int          m_port = 0;
    bit          m_we = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    bit          md[2] = '{0, 0};
    logic [31:0] m_rd[2] = '{32'h0, 32'h0};
    bit          m_ack[2] = '{0, 0};
    int          m_wc = 0;
    bit          m_err = 0;

    always @(posedge Clock_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            m_busy = 0; m_port = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            md = '{0, 0}; m_rd = '{32'h0, 32'h0}; m_ack = '{0, 0};
            m_wc = 0; m_err = 0;
        end else begin
            bit          pend[2];
            bit          req[2];
            bit          adv;
            bit          fin;
            logic [31:0] data;
            req[0] = req0_i;
            req[1] = req1_i;
            for (int p = 0; p < 2; p++) pend[p] = req[p] && !md[p];
            adv = !(pend[0] || pend[1]);
            m_ack = '{0, 0};
            if (m_busy) begin
                m_wc++;
                fin  = mem_ack_i;
                data = mem_rdata_i;
`ifdef MEM_ARB_WATCHDOG_EN
                if (!fin && m_wc == int'(TO)) begin
                    fin = 1; data = '1; m_err = 1;
                end
`endif
                if (fin) begin
                    m_busy = 0;
                    md[m_port] = 1;
                    m_ack[m_port] = 1;
                    if (!m_we) m_rd[m_port] = data;
                end
            end else begin
                // older instruction (data port) is served first
                for (int p = 1; p >= 0; p--) begin
                    if (!m_busy && pend[p]) begin
                        m_busy  = 1;
                        m_port  = p;
                        m_wc    = 0;
                        m_we    = (p == 1) && we1_i;
                        m_addr  = (p == 1) ? addr1_i : addr0_i;
                        m_wdata = (p == 1) ? wdata1_i : '0;
                    end
                end
            end
            if (adv) md = '{0, 0};
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge Clock_i) begin
        bit exp_stall;
        #2;
        exp_stall = (req0_i && !md[0]) || (req1_i && !md[1]);
        check("stall_o", stall_o, exp_stall);
        check("mem_req_o", mem_req_o, m_busy);
        if (m_busy) begin
            check("mem_we_o", mem_we_o, m_we);
            check("mem_addr_o", mem_addr_o, m_addr);
            if (m_we) check("mem_wdata_o", mem_wdata_o, m_wdata);
        end
        check("ack0_o", ack0_o, m_ack[0]);
        check("ack1_o", ack1_o, m_ack[1]);
        check("rdata0_o", rdata0_o, m_rd[0]);
        check("rdata1_o", rdata1_o, m_rd[1]);
`ifdef MEM_ARB_WATCHDOG_EN
        check("err_o", err_o, m_err);
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- stimulus ----------------
    logic        rq[1:8];
    logic        rwe[1:8];
    logic [31:0] radr[1:8];
    logic [31:0] rwd[1:8];
    int          ack0_k, ack1_k, low_k, wcnt, acts;
    bit          found, last_stall;

    initial begin
        Reset_n_i = 1'b0;
        req0_i = 1'b1; addr0_i = 32'h40;
        req1_i = 1'b0; we1_i = 1'b0; addr1_i = '0; wdata1_i = '0;

        // reset held with a fetch request pending
        @(negedge Clock_i);
        @(negedge Clock_i); #3;
        check("rst_stall", stall_o, 1'b1);
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_rdata0", rdata0_o, 32'h0);

        // fetch only, ack in the first WAIT cycle
        @(negedge Clock_i); Reset_n_i = 1'b1; #3;
        check("f_idle_stall", stall_o, 1'b1);
        @(negedge Clock_i); #3;
        check("f_req", mem_req_o, 1'b1);
        check("f_addr", mem_addr_o, 32'h40);
        check("f_we", mem_we_o, 1'b0);
        check("f_wait_stall", stall_o, 1'b1);
        @(negedge Clock_i); #3;
        check("f_ack0", ack0_o, 1'b1);
        check("f_rdata0", rdata0_o, 32'h8C22_0004);
        check("f_stall_low", stall_o, 1'b0);
        // back-to-back: request still held across the advance edge
        @(negedge Clock_i); addr0_i = 32'h44; #3;
        check("b2b_ack_gone", ack0_o, 1'b0);
        check("b2b_restall", stall_o, 1'b1);
        check("b2b_no_dup", mem_req_o, 1'b0);
        @(negedge Clock_i); #3;
        check("b2b_req", mem_req_o, 1'b1);
        check("b2b_addr", mem_addr_o, 32'h44);
        @(negedge Clock_i); req0_i = 1'b0; #3;
        check("b2b_ack0", ack0_o, 1'b1);

        // both ports, write first, two extra memory wait cycles
        @(negedge Clock_i);
        lat_cfg = 2;
        req0_i = 1'b1; addr0_i = 32'h48;
        req1_i = 1'b1; we1_i = 1'b1; addr1_i = 32'h100; wdata1_i = 32'hDEAD_BEEF;
        #3;
        check("both_idle_req", mem_req_o, 1'b0);
        ack0_k = -1; ack1_k = -1; low_k = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clock_i); #3;
            rq[k] = mem_req_o; rwe[k] = mem_we_o; radr[k] = mem_addr_o; rwd[k] = mem_wdata_o;
            if (ack1_o && ack1_k < 0) ack1_k = k;
            if (ack0_o && ack0_k < 0) ack0_k = k;
            if (!stall_o && low_k < 0) low_k = k;
        end
        check("both_w_req", rq[1], 1'b1);
        check("both_w_we", rwe[1], 1'b1);
        check("both_w_addr", radr[1], 32'h100);
        check("both_w_data", rwd[1], 32'hDEAD_BEEF);
        check("both_ack1_cyc", ack1_k, 4);
        check("both_r_req", rq[5], 1'b1);
        check("both_r_we", rwe[5], 1'b0);
        check("both_r_addr", radr[5], 32'h48);
        check("both_ack0_cyc", ack0_k, 8);
        check("both_stall_low", low_k, 8);
        check("both_rdata1", rdata1_o, 32'h0);
        check("both_rdata0", rdata0_o, 32'h8C22_0004);
        @(negedge Clock_i); req0_i = 1'b0; req1_i = 1'b0;

        // reset in the middle of an access
        @(negedge Clock_i); lat_cfg = 3; req0_i = 1'b1; addr0_i = 32'h80; #3;
        check("mid_idle", mem_req_o, 1'b0);
        @(negedge Clock_i); #3;
        check("mid_wait_req", mem_req_o, 1'b1);
        @(negedge Clock_i); Reset_n_i = 1'b0; req1_i = 1'b1; #3;
        check("mid_rst_req", mem_req_o, 1'b0);
        check("mid_rst_stall", stall_o, 1'b1);
        @(negedge Clock_i); req0_i = 1'b0; req1_i = 1'b0; #3;
        check("mid_rst_nostall", stall_o, 1'b0);
        @(negedge Clock_i); Reset_n_i = 1'b1; force_req++;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock_i); #3;
            check("late_ack0", ack0_o, 1'b0);
            check("late_ack1", ack1_o, 1'b0);
            check("late_req", mem_req_o, 1'b0);
        end

`ifdef MEM_ARB_WATCHDOG_EN
        // memory never answers
        @(negedge Clock_i); lat_cfg = 0; mem_mute = 1; req0_i = 1'b1; addr0_i = 32'hC0;
        wcnt = 0; found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge Clock_i); #3;
            if (mem_req_o) wcnt++;
            if (ack0_o) found = 1;
        end
        check("wd_ack_seen", found, 1'b1);
        check("wd_wait_cycles", wcnt, TO);
        check("wd_rdata0", rdata0_o, 32'hFFFF_FFFF);
        check("wd_err", err_o, 1'b1);
        @(negedge Clock_i); req0_i = 1'b0; mem_mute = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock_i); #3;
            check("wd_err_sticky", err_o, 1'b1);
        end
        @(negedge Clock_i); Reset_n_i = 1'b0; #3;
        check("wd_err_reset", err_o, 1'b0);
        @(negedge Clock_i); Reset_n_i = 1'b1;
`endif

        // randomized traffic
        lat_cfg = -1; use_fixed = 0; spurious_en = 1;
        last_stall = 1'b0; acts = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge Clock_i);
            if (!Reset_n_i) Reset_n_i = 1'b1;
            else if ($urandom_range(0, 399) == 0) Reset_n_i = 1'b0;
            if (!last_stall) begin
                req0_i   = ($urandom_range(0, 3) != 0);
                req1_i   = $urandom_range(0, 1) == 1;
                we1_i    = $urandom_range(0, 1) == 1;
                addr0_i  = $urandom;
                addr1_i  = $urandom;
                wdata1_i = $urandom;
            end else begin
                if ($urandom_range(0, 19) == 0) req0_i = 1'b0;
                if ($urandom_range(0, 19) == 0) req1_i = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    addr0_i  = $urandom;
                    addr1_i  = $urandom;
                    wdata1_i = $urandom;
                    we1_i    = $urandom_range(0, 1) == 1;
                end
            end
            #3;
            last_stall = stall_o;
            if (ack0_o || ack1_o) acts++;
        end
        check("rand_activity", acts > 200, 1'b1);

        @(negedge Clock_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
